// File: rtl/multicycle_control_unit.sv
// Sequencing control for the multi-cycle MIPS core: latches a decoded instruction class
// in DECODE, then steps FETCH/DECODE/EXEC/MEM/WB, stalling on waitrequest and multiply/divide latency.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   FETCH  | instruction read; hold while waitrequest, ir_write on completion
//   DECODE | one cycle; latch class, destination, access size, signedness
//   EXEC   | per-class strobes; mult/div stay here for their latency
//   MEM    | load/store transfer; hold while waitrequest
//   WB     | load write-back from memory data
//   HALT   | JR to address zero; terminal until reset
module multicycle_control_unit #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       waitrequest,
   input  logic       jr_target_zero,
   output logic       active,
   output logic       mem_read,
   output logic       mem_write,
   output logic       instr_fetch,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic       mem_to_reg,
   output logic [1:0] mem_size,
   output logic       mem_signed,
   output logic       jump,
   output logic       jr,
   output logic       branch,
   output logic       hilo_write,
   output logic       pc_write,
   output logic [2:0] state
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [3:0] C_NOP   = 4'd0;
   localparam logic [3:0] C_ALU_R = 4'd1;
   localparam logic [3:0] C_ALU_I = 4'd2;
   localparam logic [3:0] C_BR    = 4'd3;
   localparam logic [3:0] C_J     = 4'd4;
   localparam logic [3:0] C_JAL   = 4'd5;
   localparam logic [3:0] C_JALR  = 4'd6;
   localparam logic [3:0] C_JR    = 4'd7;
   localparam logic [3:0] C_MUL   = 4'd8;
   localparam logic [3:0] C_DIV   = 4'd9;
   localparam logic [3:0] C_MTHL  = 4'd10;
   localparam logic [3:0] C_MFHL  = 4'd11;
   localparam logic [3:0] C_LOAD  = 4'd12;
   localparam logic [3:0] C_STORE = 4'd13;

   localparam logic [1:0] DST_RT  = 2'd0;
   localparam logic [1:0] DST_RD  = 2'd1;
   localparam logic [1:0] DST_R31 = 2'd2;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
   localparam logic             MUL_ONE  = (MUL_CYCLES == 1);
   localparam logic             DIV_ONE  = (DIV_CYCLES == 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       cls_q, dec_cls;
   logic [1:0]       dst_q, dec_dst;
   logic [1:0]       size_q, dec_size;
   logic             sgn_q, dec_sgn;
   logic             lat_last;
   logic [CNT_W-1:0] lat_load;

   always_comb begin
      dec_cls = C_NOP;
      case (opcode)
         6'h00: begin
            case (funct)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h2A, 6'h2B:              dec_cls = C_ALU_R;
               6'h08:                                   dec_cls = C_JR;
               6'h09:                                   dec_cls = C_JALR;
               6'h10, 6'h12:                            dec_cls = C_MFHL;
               6'h11, 6'h13:                            dec_cls = C_MTHL;
               6'h18, 6'h19:                            dec_cls = C_MUL;
               6'h1A, 6'h1B:                            dec_cls = C_DIV;
               default:                                 dec_cls = C_NOP;
            endcase
         end
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07:             dec_cls = C_BR;
         6'h02:                                         dec_cls = C_J;
         6'h03:                                         dec_cls = C_JAL;
         6'h08, 6'h09, 6'h0A, 6'h0B,
         6'h0C, 6'h0D, 6'h0E, 6'h0F:                    dec_cls = C_ALU_I;
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25:             dec_cls = C_LOAD;
         6'h28, 6'h29, 6'h2B:                           dec_cls = C_STORE;
         default:                                       dec_cls = C_NOP;
      endcase
   end

   always_comb begin
      dec_dst = DST_RT;
      case (dec_cls)
         C_ALU_R, C_JALR, C_MFHL: dec_dst = DST_RD;
         C_JAL:                   dec_dst = DST_R31;
         default:                 dec_dst = DST_RT;
      endcase
   end

   // Byte/half/word is encoded in the low opcode bits for every supported load/store.
   always_comb begin
      case (opcode[1:0])
         2'b00:   dec_size = 2'd0;
         2'b01:   dec_size = 2'd1;
         default: dec_size = 2'd2;
      endcase
      dec_sgn = (opcode == 6'h20) || (opcode == 6'h21);
   end

   // A zero counter means "first EXEC cycle"; later cycles count down to 1.
   always_comb begin
      lat_load = (cls_q == C_MUL) ? MUL_LOAD : DIV_LOAD;
      if (cnt_q == '0) begin
         lat_last = (cls_q == C_MUL) ? MUL_ONE : DIV_ONE;
      end else begin
         lat_last = (cnt_q == CNT_W'(1));
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      active      = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      instr_fetch = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = DST_RT;
      mem_to_reg  = 1'b0;
      mem_size    = 2'd0;
      mem_signed  = 1'b0;
      jump        = 1'b0;
      jr          = 1'b0;
      branch      = 1'b0;
      hilo_write  = 1'b0;
      pc_write    = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read    = 1'b1;
            instr_fetch = 1'b1;
            mem_size    = 2'd2;
            if (!waitrequest) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end
         end

         S_DECODE: state_d = S_EXEC;

         S_EXEC: begin
            state_d = S_FETCH;
            case (cls_q)
               C_ALU_R, C_ALU_I, C_MFHL: begin
                  reg_write = 1'b1;
                  reg_dst   = dst_q;
                  pc_write  = 1'b1;
               end
               C_BR: begin
                  branch   = 1'b1;
                  pc_write = 1'b1;
               end
               C_J: begin
                  jump     = 1'b1;
                  pc_write = 1'b1;
               end
               C_JAL: begin
                  jump      = 1'b1;
                  pc_write  = 1'b1;
                  reg_write = 1'b1;
                  reg_dst   = dst_q;
               end
               C_JALR: begin
                  jump      = 1'b1;
                  jr        = 1'b1;
                  pc_write  = 1'b1;
                  reg_write = 1'b1;
                  reg_dst   = dst_q;
               end
               C_JR: begin
                  jr       = 1'b1;
                  pc_write = 1'b1;
                  if (jr_target_zero) state_d = S_HALT;
               end
               C_MUL, C_DIV: begin
                  if (lat_last) begin
                     hilo_write = 1'b1;
                     pc_write   = 1'b1;
                     cnt_d      = '0;
                  end else begin
                     state_d = S_EXEC;
                     cnt_d   = (cnt_q == '0) ? lat_load : cnt_q - CNT_W'(1);
                  end
               end
               C_MTHL: begin
                  hilo_write = 1'b1;
                  pc_write   = 1'b1;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               default:         pc_write = 1'b1;
            endcase
         end

         S_MEM: begin
            mem_read   = (cls_q == C_LOAD);
            mem_write  = (cls_q != C_LOAD);
            mem_size   = size_q;
            mem_signed = sgn_q;
            if (!waitrequest) begin
               if (cls_q == C_LOAD) begin
                  state_d = S_WB;
               end else begin
                  pc_write = 1'b1;
                  state_d  = S_FETCH;
               end
            end
         end

         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            reg_dst    = DST_RT;
            pc_write   = 1'b1;
            state_d    = S_FETCH;
         end

         S_HALT: active = 1'b0;

         default: state_d = S_FETCH;
      endcase

      // Strobes drop the moment reset asserts, not at the next edge.
      if (!reset_n) begin
         active      = 1'b1;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         instr_fetch = 1'b0;
         ir_write    = 1'b0;
         reg_write   = 1'b0;
         reg_dst     = DST_RT;
         mem_to_reg  = 1'b0;
         mem_size    = 2'd0;
         mem_signed  = 1'b0;
         jump        = 1'b0;
         jr          = 1'b0;
         branch      = 1'b0;
         hilo_write  = 1'b0;
         pc_write    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         cls_q   <= C_NOP;
         dst_q   <= DST_RT;
         size_q  <= 2'd0;
         sgn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_DECODE) begin
            cls_q  <= dec_cls;
            dst_q  <= dec_dst;
            size_q <= dec_size;
            sgn_q  <= dec_sgn;
         end
      end
   end

   assign state = state_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequenced control for the multi-cycle MIPS core.
- Decodes opcode/funct as the single-cycle decoder does, and also handles memory handshakes, multiply/divide latency and halt.
- Drives per-state datapath strobes in the sequence FETCH, DECODE, EXEC, MEM, WB, then back to FETCH.
- Sits between the instruction register and the datapath; all memory traffic is stalled by `waitrequest`.

Parameters:
- MUL_CYCLES, 2: EXEC-stage cycles for MULT/MULTU, must be ≥1.
- DIV_CYCLES, 32: EXEC-stage cycles for DIV/DIVU, must be ≥1.
- CNT_W, 6: latency counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from instruction register (valid from DECODE onward)
- funct  in  6  instruction[5:0]
- waitrequest  in  1  memory stall; transfer completes on a cycle with waitrequest=0
- jr_target_zero  in  1  register operand of JR equals 0x00000000
- active  out  1  high while executing; low after halt
- mem_read  out  1  memory read request (fetch or load)
- mem_write  out  1  memory write request (store)
- instr_fetch  out  1  current read is an instruction fetch
- ir_write  out  1  latch instruction register
- reg_write  out  1  register-file write enable
- reg_dst  out  2  destination select: 0=rt, 1=rd, 2=r31
- mem_to_reg  out  1  write-back data from memory
- mem_size  out  2  0=byte, 1=half, 2=word
- mem_signed  out  1  sign-extend load data
- jump  out  1  J/JAL/JALR PC update
- jr  out  1  register-target jump (JR/JALR)
- branch  out  1  BEQ/BNE/BLEZ/BGTZ/REGIMM evaluate
- hilo_write  out  1  HI/LO write (MULT/DIV completion, MTHI/MTLO)
- pc_write  out  1  commit next PC
- state  out  3  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6–7 go to FETCH.
- Reset (reset_n=0, asynchronous): state=FETCH, counter=0, active=1; every other output 0.
- All outputs are combinational from the state and latched decode. Decode fields are registered in DECODE and held until the next DECODE.
- FETCH: mem_read=instr_fetch=1 (mem_size=2). Hold while waitrequest=1. On waitrequest=0: ir_write=1 for that cycle, go to DECODE.
- DECODE: exactly one cycle; latches class, dst and size; go to EXEC.
- EXEC, ALU R-type/immediate:
  - Assert reg_write and pc_write; go to FETCH.
  - reg_dst=1 for R-type, 0 for immediate.
- EXEC, branches: branch=1 and pc_write=1; go to FETCH.
- EXEC, J: jump=1 and pc_write=1.
- EXEC, JAL: jump=1, pc_write=1, reg_write=1, reg_dst=2.
- EXEC, JALR: jump=jr=1, pc_write=1, reg_write=1, reg_dst=1.
- EXEC, JR: jr=1 and pc_write=1. If jr_target_zero=1, go to HALT instead of FETCH; pc_write is still asserted.
- EXEC, MULT/MULTU/DIV/DIVU:
  - Counter loads on the first EXEC cycle; stay in EXEC for exactly MUL_CYCLES/DIV_CYCLES cycles total.
  - On the last cycle assert hilo_write=1 and pc_write=1, then go to FETCH.
- EXEC, MTHI/MTLO: hilo_write=1 and pc_write=1 in a single cycle.
- EXEC, MFHI/MFLO: reg_write=1, reg_dst=1, pc_write=1.
- EXEC, loads/stores: no strobes; go to MEM.
- Load opcodes: LB=0x20, LH=0x21, LW=0x23, LBU=0x24, LHU=0x25.
  - mem_signed=1 for LB and LH only.
  - mem_size from opcode[1:0]: 00→0, 01→1, 11→2.
- Store opcodes: SB=0x28, SH=0x29, SW=0x2B.
- MEM: mem_read (loads) or mem_write (stores) held until waitrequest=0.
  - Stores on completion: pc_write=1, go to FETCH.
  - Loads on completion: go to WB.
- WB: reg_write=1, mem_to_reg=1, reg_dst=0, pc_write=1; go to FETCH.
- Undefined opcode/funct: treated as NOP, pc_write=1 in EXEC.
- HALT: active=0, all strobes 0; terminal until reset.
- A write to r0 is not suppressed here; the register file ignores it.
- Reset mid-MEM or mid-division: immediate return to FETCH with the counter cleared; no pending strobe survives.

Test Plan:
- ADDU (op 0x00, funct 0x21), waitrequest=0 → state trace 0,1,2,0; ir_write in cycle 0; reg_write=reg_dst=pc_write=1 in cycle 2 only.
- LH (0x21) with waitrequest=1 for 3 cycles in MEM → mem_read held 4 cycles with mem_size=1 and mem_signed=1; WB follows with reg_write=mem_to_reg=1.
- SW (0x2B), waitrequest=0 → mem_write=1 for one cycle in MEM, reg_write never asserted, next state FETCH.
- DIV (funct 0x1A) with DIV_CYCLES=32 → 32 consecutive EXEC cycles; hilo_write=pc_write=1 only on the 32nd.
- JAL (0x03) → jump=1, reg_write=1, reg_dst=2 in EXEC. JR with jr_target_zero=1 → HALT; active drops the next cycle and stays 0 for ≥10 cycles.
- reset_n pulsed low during FETCH stalled by waitrequest=1 → outputs clear asynchronously; after release, state=0 and mem_read=1.
